// File: rtl/serial_arith_pkg.sv
// rtl/serial_arith_pkg.sv - state encoding and counter-width helper for the serial subtractor
package serial_arith_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Bits needed to count 0..value-1 (at least 1).
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        if (r < 1) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// rtl/full_subtractor.sv - combinational 1-bit full subtractor cell computing x - y - bin
// x, y, bin : minuend bit, subtrahend bit, borrow in
// d, bout   : difference bit, borrow out
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial LSB-first subtractor diff = a - b with start/busy/done handshake
// clk, rst_n           : clock, asynchronous active-low reset
// start, a, b          : request and operands, captured only on the accepting edge
// busy, done           : high while shifting, one-cycle completion pulse
// diff, borrow_out     : result and underflow flag, held until the next done
// bit_out              : difference bit being produced this cycle, 0 outside SHIFT
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             bit_out
);

    localparam int CW = clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] res;
    logic             bw;
    logic [CW-1:0]    cnt;

    logic             d_bit;
    logic             bw_next;
    logic [WIDTH-1:0] res_next;

    full_subtractor u_cell (
        .x    (sa[0]),
        .y    (sb[0]),
        .bin  (bw),
        .d    (d_bit),
        .bout (bw_next)
    );

    assign res_next = {d_bit, res[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            sa         <= '0;
            sb         <= '0;
            res        <= '0;
            bw         <= 1'b0;
            cnt        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
            bit_out    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        sa      <= a;
                        sb      <= b;
                        res     <= '0;
                        bw      <= 1'b0;
                        cnt     <= '0;
                        busy    <= 1'b1;
                        // Borrow-in is zero for bit 0, so its difference is a plain XOR.
                        bit_out <= a[0] ^ b[0];
                        state   <= ST_SHIFT;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    res <= res_next;
                    bw  <= bw_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state      <= ST_DONE;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        diff       <= res_next;
                        borrow_out <= bw_next;
                        bit_out    <= 1'b0;
                    end else begin
                        // Look one bit ahead so the registered tap shows the bit the
                        // cell is working on in the coming cycle.
                        bit_out <= sa[1] ^ sb[1] ^ bw_next;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
